// File: rtl/eth_tx_tstamp_if.sv
// AXI-Stream beat bundle (64-bit data, byte keep, last) between frame stages.
// The master drives valid/data/keep/last, the slave returns ready.
interface eth_tx_tstamp_if;
  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;

  modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/eth_tx_tstamp.sv
// TX timestamp inserter: stamps each frame with the SOF cycle count; 1-cycle latency.
// Backpressure: 2-entry registered skid, s_axis.tready drops only when both entries hold beats.
module eth_tx_tstamp #(
  parameter int TS_OFFSET = 42,
  parameter int MAX_BEATS = 2048
) (
  input  logic                  clk156,
  input  logic                  reset,
  input  logic                  enable,
  eth_tx_tstamp_if.slave        s_axis,
  eth_tx_tstamp_if.master       m_axis,
  output logic [63:0]           ts_now,
  output logic                  tx_ts_valid,
  output logic [63:0]           tx_ts,
  output logic [31:0]           frame_cnt,
  output logic [15:0]           short_cnt
);

  localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [BW-1:0] BIDX_MAX = BW'(MAX_BEATS - 1);

  typedef struct packed {
    logic [63:0] dat;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef enum logic [1:0] {SK_EMPTY, SK_ONE, SK_TWO} sk_state_t;

  logic        push;
  logic        pop;
  logic        in_rdy_q;
  logic        out_vld_q;
  beat_t       out_q;
  beat_t       skid_q;
  beat_t       in_beat;
  sk_state_t   state_q;
  sk_state_t   state_d;
  logic        load_out;
  logic        load_out_skid;
  logic        load_skid;

  // Per-frame context; sof_q marks that the next accepted beat opens a frame.
  logic          sof_q;
  logic [BW-1:0] bidx_q;
  logic [63:0]   stamp_q;
  logic          en_q;
  logic          done_q;
  logic          past_q;

  logic [63:0]   stamp_cur;
  logic          en_cur;
  logic          done_cur;
  logic          past_cur;
  logic          ins_ok;
  logic [31:0]   rel [8];
  logic [63:0]   ins_dat;
  logic          hit;

  assign push = s_axis.tvalid && in_rdy_q;
  assign pop  = out_vld_q && m_axis.tready;

  assign stamp_cur = sof_q ? ts_now : stamp_q;
  assign en_cur    = sof_q ? enable : en_q;
  assign done_cur  = sof_q ? 1'b0   : done_q;
  assign past_cur  = sof_q ? 1'b0   : past_q;
  assign ins_ok    = en_cur && !past_cur;

  // rel is the lane's byte distance from TS_OFFSET; values 0..7 fall inside the stamp.
  always_comb begin
    ins_dat = s_axis.tdata;
    hit     = 1'b0;
    for (int l = 0; l < 8; l++) begin
      rel[l] = (32'(bidx_q) << 3) + 32'(l) - 32'(TS_OFFSET);
      if (ins_ok && s_axis.tkeep[l] && (rel[l] < 32'd8)) begin
        ins_dat[8*l +: 8] = stamp_cur[8*(7 - rel[l][2:0]) +: 8];
        if (rel[l][2:0] == 3'd7) begin
          hit = push;
        end
      end
    end
  end

  assign in_beat = '{dat: ins_dat, keep: s_axis.tkeep, last: s_axis.tlast};

  always_ff @(posedge clk156) begin
    if (reset) begin
      sof_q   <= 1'b1;
      bidx_q  <= '0;
      stamp_q <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      past_q  <= 1'b0;
    end else if (push) begin
      if (sof_q) begin
        stamp_q <= ts_now;
        en_q    <= enable;
      end
      if (s_axis.tlast) begin
        sof_q  <= 1'b1;
        bidx_q <= '0;
        done_q <= 1'b0;
        past_q <= 1'b0;
      end else begin
        sof_q  <= 1'b0;
        done_q <= done_cur || hit;
        past_q <= past_cur || (bidx_q == BIDX_MAX);
        if (bidx_q != BIDX_MAX) begin
          bidx_q <= bidx_q + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk156) begin
    if (reset) begin
      ts_now      <= '0;
      tx_ts_valid <= 1'b0;
      tx_ts       <= '0;
      frame_cnt   <= '0;
      short_cnt   <= '0;
    end else begin
      ts_now      <= ts_now + 64'd1;
      tx_ts_valid <= hit;
      if (hit) begin
        tx_ts <= stamp_cur;
      end
      if (push && s_axis.tlast) begin
        frame_cnt <= frame_cnt + 32'd1;
        if (en_cur && !done_cur && !hit) begin
          short_cnt <= short_cnt + 16'd1;
        end
      end
    end
  end

  // Skid occupancy FSM: out_q is the head presented to the MAC, skid_q the second entry.
  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state_q)
      SK_EMPTY: begin
        if (push) begin
          load_out = 1'b1;
          state_d  = SK_ONE;
        end
      end
      SK_ONE: begin
        if (push && pop) begin
          load_out = 1'b1;
        end else if (push) begin
          load_skid = 1'b1;
          state_d   = SK_TWO;
        end else if (pop) begin
          state_d = SK_EMPTY;
        end
      end
      SK_TWO: begin
        if (pop) begin
          load_out_skid = 1'b1;
          if (push) begin
            load_skid = 1'b1;
          end else begin
            state_d = SK_ONE;
          end
        end
      end
      default: state_d = SK_EMPTY;
    endcase
  end

  always_ff @(posedge clk156) begin
    if (reset) begin
      state_q   <= SK_EMPTY;
      out_q     <= '0;
      skid_q    <= '0;
      out_vld_q <= 1'b0;
      in_rdy_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_vld_q <= (state_d != SK_EMPTY);
      in_rdy_q  <= (state_d != SK_TWO);
      if (load_out) begin
        out_q <= in_beat;
      end else if (load_out_skid) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_beat;
      end
    end
  end

  assign s_axis.tready = in_rdy_q;
  assign m_axis.tvalid = out_vld_q;
  assign m_axis.tdata  = out_q.dat;
  assign m_axis.tkeep  = out_q.keep;
  assign m_axis.tlast  = out_q.last;

endmodule

// File: tb/tb_eth_tx_tstamp.sv
// Bench for eth_tx_tstamp: frame vector table plus directed SOF/reset/back-to-back sequences,
// with a byte-level scoreboard of the expected stamped stream.
module tb_eth_tx_tstamp;

  logic        clk156 = 1'b0;
  logic        reset  = 1'b1;
  logic        enable = 1'b0;
  logic [63:0] ts_now;
  logic        tx_ts_valid;
  logic [63:0] tx_ts;
  logic [31:0] frame_cnt;
  logic [15:0] short_cnt;

  eth_tx_tstamp_if s_axis ();
  eth_tx_tstamp_if m_axis ();

  eth_tx_tstamp dut (
    .clk156      (clk156),
    .reset       (reset),
    .enable      (enable),
    .s_axis      (s_axis),
    .m_axis      (m_axis),
    .ts_now      (ts_now),
    .tx_ts_valid (tx_ts_valid),
    .tx_ts       (tx_ts),
    .frame_cnt   (frame_cnt),
    .short_cnt   (short_cnt)
  );

  always #5 clk156 = ~clk156;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected cycle count: mirrors the free-running counter definition.
  logic [63:0] tcnt;
  logic        rst_d;
  always @(posedge clk156) begin
    tcnt  <= reset ? 64'd0 : tcnt + 64'd1;
    rst_d <= reset;
  end

  typedef struct {
    logic [63:0] dat;
    logic [7:0]  keep;
    logic        last;
    logic [63:0] t;
    bit          sof;
  } ob_t;

  ob_t         expq [$];
  logic [63:0] exp_ts [$];
  logic [63:0] odat [$];
  logic [63:0] ts_hist [$];
  int          occ = 0;
  int          m_bidx = 0;
  logic [63:0] m_stamp = '0;
  bit          m_en = 1'b0;
  logic [63:0] last_exp_ts = '0;
  int          pulse_cnt = 0;
  int          sof_lat = -1;
  int          fid = 0;
  bit          tog = 1'b0;
  ob_t         e_in;
  ob_t         e_out;
  logic [63:0] d_in;
  int          rel;

  always @(negedge clk156) begin
    if (!reset) begin
      if (!rst_d) begin
        chk("s_tready_vs_occupancy", s_axis.tready, (occ < 2));
        chk("m_tvalid_vs_occupancy", m_axis.tvalid, (occ > 0));
      end
      if (tx_ts_valid) begin
        pulse_cnt++;
        ts_hist.push_back(tx_ts);
        if (exp_ts.size() == 0) begin
          chk("unexpected_tx_ts_valid", 64'd1, 64'd0);
        end else begin
          chk("tx_ts_value", tx_ts, exp_ts.pop_front());
        end
      end
      if (m_axis.tvalid && m_axis.tready) begin
        if (expq.size() == 0) begin
          chk("unexpected_out_beat", 64'd1, 64'd0);
        end else begin
          e_out = expq.pop_front();
          chk("out_tdata", m_axis.tdata, e_out.dat);
          chk("out_tkeep", m_axis.tkeep, e_out.keep);
          chk("out_tlast", m_axis.tlast, e_out.last);
          if (e_out.sof) sof_lat = int'(tcnt - e_out.t);
        end
        odat.push_back(m_axis.tdata);
        occ--;
      end
      if (s_axis.tvalid && s_axis.tready) begin
        if (m_bidx == 0) begin
          m_stamp = tcnt;
          m_en    = enable;
        end
        d_in = s_axis.tdata;
        for (int l = 0; l < 8; l++) begin
          rel = m_bidx * 8 + l - 42;
          if (m_en && s_axis.tkeep[l] && rel >= 0 && rel < 8) begin
            d_in[8*l +: 8] = m_stamp[63 - 8*rel -: 8];
            if (rel == 7) begin
              exp_ts.push_back(m_stamp);
              last_exp_ts = m_stamp;
            end
          end
        end
        e_in = '{dat: d_in, keep: s_axis.tkeep, last: s_axis.tlast, t: tcnt, sof: (m_bidx == 0)};
        expq.push_back(e_in);
        occ++;
        m_bidx = s_axis.tlast ? 0 : m_bidx + 1;
      end
    end
  end

  // Frame byte n of frame f carries (n + 17*f); lanes beyond tkeep still carry the pattern.
  task automatic send_frame(input int nbytes, input bit en, input bit en_mid, input int stop_after);
    int nb;
    int rem;
    int n;
    logic [63:0] d;
    logic [7:0]  k;
    nb = (nbytes + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      if (stop_after >= 0 && b >= stop_after) break;
      for (int l = 0; l < 8; l++) d[8*l +: 8] = 8'(b * 8 + l + 17 * fid);
      rem = nbytes - b * 8;
      k   = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = d;
      s_axis.tkeep  = k;
      s_axis.tlast  = (b == nb - 1);
      if (b == 0) enable = en;
      if (b == 2 && en_mid) enable = 1'b1;
      n = 0;
      forever begin
        @(negedge clk156);
        if (s_axis.tready) break;
        n++;
        if (n > 200) begin
          $display("FAIL accept_timeout: actual=stalled required=accepted");
          $fatal(1, "s_axis never ready");
        end
      end
      @(posedge clk156);
      #1;
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    fid++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || exp_ts.size() != 0) && n < 300) begin
      @(posedge clk156);
      #1;
      n++;
    end
    repeat (3) begin
      @(posedge clk156);
      #1;
    end
    chk("drain_out_queue_empty", 64'(expq.size()), 64'd0);
    chk("drain_stamp_queue_empty", 64'(exp_ts.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk156);
    #1;
    reset = 1'b0;
    expq.delete();
    exp_ts.delete();
    odat.delete();
    occ         = 0;
    m_bidx      = 0;
    last_exp_ts = '0;
  endtask

  typedef struct {
    int nbytes;
    bit en;
    bit en_mid;
    bit toggle;
    int exp_pulses;
    int exp_frames;
    int exp_short;
  } vec_t;

  vec_t vecs [9];
  int   p0;
  int   n;

  initial begin
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tkeep  = '0;
    s_axis.tlast  = 1'b0;
    m_axis.tready = 1'b1;

    vecs[0] = '{60, 1'b1, 1'b0, 1'b1, 1, 2, 0};
    vecs[1] = '{60, 1'b1, 1'b0, 1'b1, 1, 3, 0};
    vecs[2] = '{60, 1'b0, 1'b1, 1'b0, 0, 4, 0};
    vecs[3] = '{60, 1'b1, 1'b0, 1'b0, 1, 5, 0};
    vecs[4] = '{46, 1'b1, 1'b0, 1'b0, 0, 6, 1};
    vecs[5] = '{60, 1'b0, 1'b0, 1'b1, 0, 7, 1};
    vecs[6] = '{16, 1'b1, 1'b0, 1'b0, 0, 8, 2};
    vecs[7] = '{50, 1'b1, 1'b0, 1'b1, 1, 9, 2};
    vecs[8] = '{49, 1'b1, 1'b0, 1'b0, 0, 10, 3};

    fork
      forever begin
        @(posedge clk156);
        #1;
        m_axis.tready = tog ? ~m_axis.tready : 1'b1;
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk156);
    @(negedge clk156);
    chk("rst_ts_now", ts_now, 64'd0);
    chk("rst_tx_ts", tx_ts, 64'd0);
    chk("rst_tx_ts_valid", tx_ts_valid, 64'd0);
    chk("rst_frame_cnt", frame_cnt, 64'd0);
    chk("rst_short_cnt", short_cnt, 64'd0);
    chk("rst_m_tvalid", m_axis.tvalid, 64'd0);
    chk("rst_m_tdata", m_axis.tdata, 64'd0);
    chk("rst_m_tkeep", m_axis.tkeep, 64'd0);
    chk("rst_m_tlast", m_axis.tlast, 64'd0);
    chk("rst_s_tready", s_axis.tready, 64'd0);
    @(posedge clk156);
    #1;
    reset = 1'b0;
    @(negedge clk156);
    chk("s_tready_during_last_reset_cycle", s_axis.tready, 64'd0);
    @(negedge clk156);
    chk("s_tready_first_cycle_after_reset", s_axis.tready, 64'd1);
    chk("ts_now_first_cycle_after_reset", ts_now, 64'd1);
    @(posedge clk156);
    #1;

    // Single 60 B frame with SOF accepted at ts_now = 0x100
    n = 0;
    while (tcnt != 64'h100 && n < 400) begin
      @(posedge clk156);
      #1;
      n++;
    end
    send_frame(60, 1'b1, 1'b0, -1);
    drain();
    chk("t1_tx_ts", tx_ts, 64'h100);
    chk("t1_pulses", 64'(pulse_cnt), 64'd1);
    chk("t1_frame_cnt", frame_cnt, 64'd1);
    chk("t1_short_cnt", short_cnt, 64'd0);
    chk("t1_sof_latency", 64'(sof_lat), 64'd1);
    chk("t1_beat_count", 64'(odat.size()), 64'd8);
    if (odat.size() == 8) begin
      chk("t1_beat0", odat[0], 64'h0706050403020100);
      chk("t1_beat5", odat[5], 64'h0000000000002928);
      chk("t1_beat6", odat[6], 64'h3736353433320001);
      chk("t1_beat7", odat[7], 64'h3F3E3D3C3B3A3938);
    end

    // Table: toggling backpressure, enable off/mid-frame, short and boundary lengths
    foreach (vecs[i]) begin
      tog = vecs[i].toggle;
      p0  = pulse_cnt;
      send_frame(vecs[i].nbytes, vecs[i].en, vecs[i].en_mid, -1);
      tog = 1'b0;
      drain();
      chk($sformatf("v%0d_pulses", i), 64'(pulse_cnt - p0), 64'(vecs[i].exp_pulses));
      chk($sformatf("v%0d_frame_cnt", i), frame_cnt, 64'(vecs[i].exp_frames));
      chk($sformatf("v%0d_short_cnt", i), short_cnt, 64'(vecs[i].exp_short));
      chk($sformatf("v%0d_tx_ts_held", i), tx_ts, last_exp_ts);
      chk($sformatf("v%0d_ts_now", i), ts_now, tcnt);
    end

    // Back-to-back 60 B frames at full rate: stamps 8 cycles apart
    tog = 1'b0;
    ts_hist.delete();
    send_frame(60, 1'b1, 1'b0, -1);
    send_frame(60, 1'b1, 1'b0, -1);
    send_frame(60, 1'b1, 1'b0, -1);
    drain();
    chk("b2b_stamp_count", 64'(ts_hist.size()), 64'd3);
    if (ts_hist.size() == 3) begin
      chk("b2b_delta_01", ts_hist[1] - ts_hist[0], 64'd8);
      chk("b2b_delta_12", ts_hist[2] - ts_hist[1], 64'd8);
    end
    chk("b2b_frame_cnt", frame_cnt, 64'd13);
    chk("b2b_sof_latency", 64'(sof_lat), 64'd1);

    // Reset after beat 3 of a frame, then a fresh frame at ts_now = 0x20
    send_frame(60, 1'b1, 1'b0, 4);
    do_reset();
    @(negedge clk156);
    chk("mid_rst_m_tvalid", m_axis.tvalid, 64'd0);
    chk("mid_rst_ts_now", ts_now, 64'd0);
    chk("mid_rst_frame_cnt", frame_cnt, 64'd0);
    chk("mid_rst_short_cnt", short_cnt, 64'd0);
    chk("mid_rst_tx_ts", tx_ts, 64'd0);
    @(posedge clk156);
    #1;
    p0 = pulse_cnt;
    n  = 0;
    while (tcnt != 64'h20 && n < 100) begin
      @(posedge clk156);
      #1;
      n++;
    end
    send_frame(60, 1'b1, 1'b0, -1);
    drain();
    chk("post_rst_tx_ts", tx_ts, 64'h20);
    chk("post_rst_pulses", 64'(pulse_cnt - p0), 64'd1);
    chk("post_rst_frame_cnt", frame_cnt, 64'd1);
    chk("post_rst_beat_count", 64'(odat.size()), 64'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/eth_tx_tstamp.md
Name: eth_tx_tstamp

Overview:
- Egress stage between the UDP frame generator and the 10G MAC TX AXI-Stream port.
- Free-running 64-bit cycle counter on clk156. Each frame is stamped with the counter value latched when its first beat is accepted.
- The stamp is written big-endian into the frame at byte offset TS_OFFSET (default: first UDP payload byte). Frames pass through a 2-entry skid buffer.
- The stamped value is also reported on a side port for host logging. The UDP checksum is not modified; the generator sends it as 0.

Parameters:
- TS_OFFSET, 42, frame byte index of the first timestamp byte (byte 0 = first byte of the dest MAC); legal range 0..16376.
- MAX_BEATS, 2048, beat-index counter limit; the counter saturates at MAX_BEATS-1.

Ports:
- clk156 input 1: 156.25 MHz clock.
- reset input 1: reset, synchronous, active-high.
- enable input 1: stamping enable, sampled on the SOF beat.
- s_axis_tvalid input 1: upstream valid.
- s_axis_tready output 1: upstream ready.
- s_axis_tdata input 64: frame data; byte lane L = tdata[8L+7:8L], carrying frame byte 8*beat+L.
- s_axis_tkeep input 8: lane valid.
- s_axis_tlast input 1: last beat of frame.
- m_axis_tvalid output 1: to MAC.
- m_axis_tready input 1: from MAC.
- m_axis_tdata output 64: to MAC.
- m_axis_tkeep output 8: to MAC.
- m_axis_tlast output 1: to MAC.
- ts_now output 64: free-running counter value.
- tx_ts_valid output 1: one-cycle pulse when a frame has been fully stamped.
- tx_ts output 64: stamp of the most recent fully stamped frame.
- frame_cnt output 32: frames accepted (tlast beats), wraps.
- short_cnt output 16: stamped frames that ended before TS_OFFSET+8 bytes, wraps.

Behaviour:
- Reset values: ts_now=0, tx_ts=0, tx_ts_valid=0, frame_cnt=0, short_cnt=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, s_axis_tready=0. s_axis_tready becomes 1 on the first cycle after reset deasserts.
- ts_now increments by 1 every cycle and wraps from 2^64-1 to 0.
- Slave side:
  - Beat accepted when s_axis_tvalid && s_axis_tready.
  - Beat index counter resets to 0 after a tlast beat and after reset. The first accepted beat after either is SOF.
  - On SOF: latch stamp = ts_now of that cycle, and latch en_f = enable.
- Insertion, applied to a beat before it enters the skid buffer, only when en_f=1:
  - For i=0..7, frame byte TS_OFFSET+i is replaced by stamp[63-8i -: 8], but only if that lane's tkeep bit is 1.
  - A stamp may straddle two beats, e.g. offset 42 uses beat 5 lanes 2..7 and beat 6 lanes 0..1.
  - All other bytes, tkeep and tlast pass unchanged.
- Completion and error reporting, only when en_f=1:
  - When byte TS_OFFSET+7 is written: tx_ts <= stamp, and tx_ts_valid pulses in the following cycle.
  - If tlast is accepted before byte TS_OFFSET+7: short_cnt+1, no pulse, tx_ts unchanged.
- frame_cnt+1 on every accepted tlast beat, regardless of enable.
- Skid buffer:
  - 2 entries. s_axis_tready = (occupancy < 2), registered.
  - Minimum latency is 1 cycle: a beat accepted in cycle N is presented on m_axis in cycle N+1.
  - m_axis outputs are registered and hold stable while m_axis_tvalid && !m_axis_tready.
  - Simultaneous push and pop keeps occupancy unchanged.
  - No beat is dropped, duplicated or reordered.
  - Full throughput, one beat per cycle, when m_axis_tready=1.
- enable changing mid-frame has no effect until the next SOF.
- Beat index saturates at MAX_BEATS-1, with no insertion past TS_OFFSET range.
- Reset mid-frame: skid contents discarded, m_axis_tvalid=0 the cycle after reset is sampled, all counters cleared. The next accepted beat is SOF.

Test Plan:
1. Single 60 B frame (7 beats of tkeep FF, then tkeep 0F), enable=1, SOF accepted at ts_now=0x100 -> beat5 lanes2..7 = 00×6; beat6 lanes0..1 = 01,00; all other bytes identical to input; tx_ts_valid pulses once with tx_ts=0x100; frame_cnt=1; output beat 0 appears 1 cycle after acceptance.
2. Continuous 60 B frames with m_axis_tready toggling 1,0,1,0 -> s_axis_tready low only when 2 beats are buffered; output byte stream equals the expected stamped stream with no loss or duplication; each stamp equals its SOF acceptance cycle value.
3. enable=0 for one frame, with enable raised mid-frame -> that frame is output bit-identical to input, no tx_ts_valid, frame_cnt increments; the next frame is stamped.
4. 46 B frame (5 beats FF, then tkeep 3F), enable=1 -> bytes 42..45 = top 4 stamp bytes; short_cnt=1; no tx_ts_valid; tx_ts unchanged.
5. Back-to-back 60 B frames, m_axis_tready=1 -> consecutive stamps differ by exactly 8; tlast/tkeep preserved.
6. Reset asserted after beat 3 of a frame is accepted -> m_axis_tvalid=0 next cycle, ts_now=0 and counters=0; the following frame is stamped with its SOF cycle count (since reset) and its beat 0 is treated as SOF.
